// File: rtl/aes_key_schedule_ctrl_if.sv
// Key-load and round-key read port between the key schedule and its users.
interface aes_key_schedule_ctrl_if;
  logic [127:0] key_in;
  logic         key_load;
  logic         busy;
  logic         keys_valid;
  logic         rd_en;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;
  logic         rd_valid;

  modport master (output key_in, key_load, rd_en, rd_addr,
                  input  busy, keys_valid, rd_data, rd_valid);
  modport slave  (input  key_in, key_load, rd_en, rd_addr,
                  output busy, keys_valid, rd_data, rd_valid);
endinterface

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key expansion: one round key per cycle into a register bank,
// served through a registered read port.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, b;

  // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
  always_comb begin
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    b    = gmul(x252, x2);
    y    = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  end
endmodule

module aes_round_key_gen (
  input  logic [127:0] inkey,
  input  logic [3:0]   rc,
  output logic [127:0] outkey
);
  logic [3:0][7:0] rot_w, sub_w;
  logic [31:0]     temp, n0, n1, n2, n3;
  logic [7:0]      rcon;

  assign rot_w = {inkey[23:0], inkey[31:24]};

  aes_sbox u_sbox [3:0] (.a(rot_w), .y(sub_w));

  always_comb begin
    case (rc)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    temp   = sub_w ^ {rcon, 24'h0};
    n0     = inkey[127:96] ^ temp;
    n1     = inkey[95:64]  ^ n0;
    n2     = inkey[63:32]  ^ n1;
    n3     = inkey[31:0]   ^ n2;
    outkey = {n0, n1, n2, n3};
  end
endmodule

module aes_key_schedule_ctrl #(
  parameter int ROUNDS = 10
) (
  input logic                    clk,
  input logic                    rst,
  aes_key_schedule_ctrl_if.slave kif
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  localparam logic [3:0] LAST = 4'(ROUNDS);

  state_t                   state_q, state_d;
  logic [3:0]               rc_q, rc_d;
  logic [127:0]             work_q, work_d, gen_key;
  logic [127:0]             rd_data_q, rd_data_d;
  logic                     busy_q, busy_d, kv_q, kv_d, rd_valid_q, rd_valid_d, rd_ok;
  logic [ROUNDS:0][127:0]   bank_q, bank_d;

  aes_round_key_gen u_gen (.inkey(work_q), .rc(rc_q), .outkey(gen_key));

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    work_d  = work_q;
    bank_d  = bank_q;
    busy_d  = busy_q;
    kv_d    = kv_q;
    case (state_q)
      IDLE, READY: if (kif.key_load) begin
        bank_d[0] = kif.key_in;
        work_d    = kif.key_in;
        rc_d      = '0;
        state_d   = EXPAND;
        busy_d    = 1'b1;
        kv_d      = 1'b0;
      end
      EXPAND: begin
        bank_d[rc_q + 4'd1] = gen_key;
        work_d              = gen_key;
        rc_d                = rc_q + 4'd1;
        if (rc_q == LAST - 4'd1) begin
          state_d = READY;
          busy_d  = 1'b0;
          kv_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reads sample the bank before this edge, so a reload returns the old key.
    rd_ok      = kif.rd_en && kv_q && (kif.rd_addr <= LAST);
    rd_valid_d = rd_ok;
    rd_data_d  = rd_ok ? bank_q[kif.rd_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rc_q       <= '0;
      work_q     <= '0;
      busy_q     <= 1'b0;
      kv_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rc_q       <= rc_d;
      work_q     <= work_d;
      busy_q     <= busy_d;
      kv_q       <= kv_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Bank needs no reset: it is unreadable until an expansion completes.
  always_ff @(posedge clk) bank_q <= bank_d;

  assign kif.busy       = busy_q;
  assign kif.keys_valid = kv_q;
  assign kif.rd_data    = rd_data_q;
  assign kif.rd_valid   = rd_valid_q;
endmodule
